// File: rtl/gray_bin_pipe.sv
// Gray/binary code converter behind a STAGES-deep valid/ready pipeline.
// Each word carries its own mode; the conversion sits in front of stage 1.
module gray_bin_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_mode,
    output logic [WIDTH-1:0] out_data
);

    logic             adv;
    logic [WIDTH-1:0] g2b_word;
    logic [WIDTH-1:0] b2g_word;
    logic [WIDTH-1:0] conv_word;

    logic             valid_reg [STAGES];
    logic             mode_reg  [STAGES];
    logic [WIDTH-1:0] data_reg  [STAGES];

    // The whole pipe moves as one; a bubble at the output lets it advance.
    assign adv      = out_ready || !out_valid;
    assign in_ready = adv;

    genvar gi;

    // Binary bit i is the parity of all Gray bits at or above i.
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_g2b
            assign g2b_word[gi] = ^in_data[WIDTH-1:gi];
        end
    endgenerate

    assign b2g_word  = in_data ^ (in_data >> 1);
    assign conv_word = in_mode ? b2g_word : g2b_word;

    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic             valid_next;
            logic             mode_next;
            logic [WIDTH-1:0] data_next;

            if (gi == 0) begin : g_head
                assign valid_next = in_valid;
                assign mode_next  = in_mode;
                assign data_next  = conv_word;
            end else begin : g_body
                assign valid_next = valid_reg[gi-1];
                assign mode_next  = mode_reg[gi-1];
                assign data_next  = data_reg[gi-1];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg[gi] <= 1'b0;
                    mode_reg[gi]  <= 1'b0;
                    data_reg[gi]  <= '0;
                end else if (adv) begin
                    valid_reg[gi] <= valid_next;
                    mode_reg[gi]  <= mode_next;
                    data_reg[gi]  <= data_next;
                end
            end
        end
    endgenerate

    assign out_valid = valid_reg[STAGES-1];
    assign out_mode  = mode_reg[STAGES-1];
    assign out_data  = data_reg[STAGES-1];

endmodule

// File: doc/gray_bin_pipe.md
GRAY_BIN_PIPE -- requirements
Module: gray_bin_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits; legal range 1..64.
REQ-002 SHALL have parameter STAGES, default 2, pipeline depth in register stages; legal range 1..8.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid, input, 1, input word present.
REQ-006 SHALL have port in_ready, output, 1, block accepts the input word this cycle.
REQ-007 SHALL have port in_mode, input, 1, conversion select: 0 = Gray-to-binary, 1 = binary-to-Gray.
REQ-008 SHALL have port in_data, input, WIDTH, word to convert.
REQ-009 SHALL have port out_valid, output, 1, converted word present.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts the output word.
REQ-011 SHALL have port out_mode, output, WIDTH-independent 1 bit, the mode travelling with out_data.
REQ-012 SHALL have port out_data, output, WIDTH, converted word.

Function
REQ-013 Gray-to-binary SHALL give out_data[i] = XOR of in_data[WIDTH-1:i] for every i.
REQ-014 Binary-to-Gray SHALL give out_data = in_data XOR (in_data >> 1), with out_data[WIDTH-1] = in_data[WIDTH-1].
REQ-015 in_mode SHALL be captured with its word and applied per word; mixed modes in flight SHALL each convert correctly.
REQ-016 Transfer SHALL occur on an input cycle with in_valid && in_ready, and on an output cycle with out_valid && out_ready.
REQ-017 Advance signal adv = out_ready || !out_valid; in_ready SHALL equal adv combinationally.
REQ-018 When adv = 1, every stage SHALL shift one position: stage 1 loads {in_valid, in_mode, converted word}, and stage k loads stage k-1.
REQ-019 When adv = 0, all stages SHALL hold, including their valid bits, data, and mode.
REQ-020 out_valid, out_mode, and out_data SHALL be the registered contents of stage STAGES; no combinational path from in_data to out_data.
REQ-021 Latency with out_ready held 1 SHALL be exactly STAGES cycles from accept to out_valid.
REQ-022 Throughput SHALL be one word per cycle while out_ready = 1.
REQ-023 Bubbles (in_valid = 0 while adv = 1) SHALL propagate as invalid stages; they are not collapsed.
REQ-024 Words SHALL leave in acceptance order, and none SHALL be dropped or duplicated.
REQ-025 While out_valid = 1 and out_ready = 0, out_data and out_mode SHALL remain stable until transfer.
REQ-026 The conversion logic placement across stages is free, but REQ-020/021 timing SHALL hold.
REQ-027 When WIDTH = 1, both modes SHALL be identity.
REQ-028 Input data SHALL be ignored (not loaded as valid) when in_valid = 0; stage data may then load don't-care.

Reset
REQ-029 When rst_n = 0, all stage valid bits SHALL clear immediately (asynchronous), independent of clk.
REQ-030 During reset, out_valid = 0, out_mode = 0, out_data = 0, and in_ready = 1.
REQ-031 Reset mid-stream SHALL discard all in-flight words; none SHALL appear after release.
REQ-032 The first accept after reset SHALL be on the first rising clk edge with rst_n = 1.

Verification (WIDTH=8, STAGES=2 unless stated)
REQ-033 Gray-to-binary directed check: in_mode = 0 with 8'h80, 8'h07, 8'h00, then 8'hFF, and out_ready = 1. Required outputs, each 2 cycles after its accept: 8'hFF, 8'h05, 8'h00, 8'hAA.
REQ-034 Binary-to-Gray directed check: in_mode = 1 with 8'h05, 8'hFF, then 8'h7F. Required outputs: 8'h07, 8'h80, 8'h40, with out_mode = 1.
REQ-035 Backpressure: stream 8 words back-to-back and drop out_ready for 3 cycles mid-stream. Required: in_ready = 0 during those cycles, the output holds stable, all 8 words arrive in order, and there is no loss or duplication.
REQ-036 Round trip: exhaustively feed all 256 values binary-to-Gray, then feed the outputs Gray-to-binary. Required: every result equals the original value, and adjacent Gray outputs differ in exactly one bit.
REQ-037 Reset: with 2 words in flight, pull rst_n low between clock edges. Required: out_valid = 0 at once, and no stale word appears in 4 cycles after release.
REQ-038 Parameter sweep: WIDTH ∈ {1, 5, 32} and STAGES ∈ {1, 4} with random mode/data and random out_ready. Required: results match the reference model, and latency equals STAGES cycles when unstalled.
